// File: rtl/sev_seg_pkg.sv
// Shared seven-segment definitions: segment encoding, hex glyph table, digit bound.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package sev_seg_pkg;

  // Segment bit order: a..g on bits 6..0.
  localparam logic [6:0] SEG_BLANK  = 7'h7F;  // all segments off on the active-low pins
  localparam int         MAX_DIGITS = 8;      // widest display this driver scans

  // Hex glyph table, active-high abcdefg.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'h0:    g = 7'h7E;
      4'h1:    g = 7'h30;
      4'h2:    g = 7'h6D;
      4'h3:    g = 7'h79;
      4'h4:    g = 7'h33;
      4'h5:    g = 7'h5B;
      4'h6:    g = 7'h5F;
      4'h7:    g = 7'h72;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h73;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h1F;
      4'hC:    g = 7'h4E;
      4'hD:    g = 7'h3D;
      4'hE:    g = 7'h4F;
      default: g = 7'h47;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sev_seg_decode.sv
// Hex nibble to active-high abcdefg segment pattern.
// Latency: combinational.
// Backpressure: none.
module sev_seg_decode
  import sev_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = hex_glyph(nibble);

endmodule

// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with tear-free frame-boundary updates.
// Latency: outputs registered one cycle after prescaler/index/active state; load shows within one frame + 1 cycle.
// Backpressure: none; load is a fire-and-forget strobe, last load before a frame wrap wins.
module sev_seg_scan_driver
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [BLK_W-1:0] BLK_HALF  = BLK_W'(BLINK_FRAMES / 2);

  // Scan state
  logic [PRE_W-1:0] pre;
  logic [IDX_W-1:0] idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             wrap_q;

  // Display data: pending is the staging copy, active is what is shown
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_vld;
  logic [4*NUM_DIGITS-1:0] act_val;
  logic [NUM_DIGITS-1:0]   act_dp;

  // Next-state values for the output registers
  logic                  slot_end;
  logic                  frame_wrap;
  logic                  blink_off;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic [6:0]            glyph;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign slot_end   = (pre == PRE_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);
  assign blink_off  = blink_en && (blink_cnt >= BLK_HALF);

  // Prescaler, digit index and blink frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pre       <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= frame_wrap;
      if (slot_end) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      if (frame_wrap) begin
        blink_cnt <= (blink_cnt == BLK_LAST) ? '0 : blink_cnt + 1'b1;
      end
    end
  end

  // Pending capture and frame-boundary transfer; a same-cycle load lands in pending after the transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
      act_val  <= '0;
      act_dp   <= '0;
    end else begin
      if (frame_wrap && pend_vld) begin
        act_val  <= pend_val;
        act_dp   <= pend_dp;
        pend_vld <= 1'b0;
      end
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while every nibble seen so far is zero
  always_comb begin
    logic zero_above;
    logic nib_zero;
    lz_mask    = '0;
    zero_above = 1'b1;
    nib_zero   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib_zero   = (act_val[4*i +: 4] == 4'h0);
      lz_mask[i] = (i > 0) && blank_lz && nib_zero && zero_above && !act_dp[i];
      zero_above = zero_above && nib_zero;
    end
  end

  // Select the current digit's nibble, dp and suppression bit, and its anode one-hot
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib      = act_val[4*i +: 4];
        cur_dp       = act_dp[i];
        cur_lz       = lz_mask[i];
        an_onehot[i] = 1'b1;
      end
    end
  end

  sev_seg_decode u_decode (
    .nibble (cur_nib),
    .segs   (glyph)
  );

  // Anodes stay dark during the last prescaler tick so the segment change never ghosts onto the next digit
  always_comb begin
    seg_next = cur_lz ? SEG_BLANK : ~glyph;
    dp_next  = cur_lz ? 1'b1 : ~cur_dp;
    an_next  = (slot_end || blink_off) ? '1 : ~an_onehot;
  end

  // Registered pin drivers; frame_done lines up with the first anode of the new frame
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next;
      dp         <= dp_next;
      an         <= an_next;
      frame_done <= wrap_q;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Directed bench for sev_seg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=4.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Expected segment codes are hand-inverted glyphs.
module tb_sev_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic        blink_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int total;
  int bad;

  sev_seg_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLINK_FRAMES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"},  32'(dp), 32'h1);
    check({tag, "_an"},  32'(an), 32'hF);
    check({tag, "_fd"},  32'(frame_done), 32'h0);
  endtask

  // Checks one full 16-cycle frame starting at the cycle where digit 0 first lights.
  // segs = {d3,d2,d1,d0} active-low codes, dps = expected dp pin per digit.
  // Optional loads are issued at frame cycle la and lb (-1 = none).
  task automatic run_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps,
                           input logic fd0, input logic dark,
                           input int la, input logic [15:0] va, input logic [3:0] pa,
                           input int lb, input logic [15:0] vb, input logic [3:0] pb);
    for (int j = 0; j < 16; j++) begin
      int d;
      int s;
      logic [3:0] exp_an;
      d = j / 4;
      s = j % 4;
      exp_an = (dark || s == 3) ? 4'hF : ~(4'b0001 << d);
      check($sformatf("%s_an_c%0d", tag, j), 32'(an), 32'(exp_an));
      if (exp_an != 4'hF) begin
        check($sformatf("%s_seg_c%0d", tag, j), 32'(seg), 32'(segs[7*d +: 7]));
        check($sformatf("%s_dp_c%0d", tag, j), 32'(dp), 32'(dps[d]));
      end
      check($sformatf("%s_fd_c%0d", tag, j), 32'(frame_done), (j == 0) ? 32'(fd0) : 32'h0);
      if (j == la) begin
        value = va; dp_in = pa; load = 1'b1;
      end else if (j == lb) begin
        value = vb; dp_in = pb; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  localparam logic [27:0] ZEROS  = {7'h01, 7'h01, 7'h01, 7'h01};
  localparam logic [27:0] V12AF  = {7'h4F, 7'h12, 7'h08, 7'h38};
  localparam logic [27:0] V5678  = {7'h24, 7'h20, 7'h0D, 7'h00};
  localparam logic [27:0] LZ5    = {7'h7F, 7'h7F, 7'h7F, 7'h24};
  localparam logic [27:0] LZ5DP  = {7'h7F, 7'h01, 7'h7F, 7'h24};
  localparam logic [27:0] LZ0    = {7'h7F, 7'h7F, 7'h7F, 7'h01};

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    value    = 16'h0;
    dp_in    = 4'h0;
    load     = 1'b0;
    blank_lz = 1'b0;
    blink_en = 1'b0;

    // Reset held 3 cycles, outputs hold reset values in the cycle after release
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    check_reset_outputs("rst_release");
    @(negedge clk);

    // Frame 0 shows 0000; 12AF loaded mid-frame must not appear until the next frame
    run_frame("f0_zero", ZEROS, 4'hF, 1'b0, 1'b0, 1, 16'h12AF, 4'h0, -1, 16'h0, 4'h0);
    run_frame("f1_12af", V12AF, 4'hF, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Tear-free: two loads mid-frame, current frame unchanged, last load wins
    run_frame("f2_tear", V12AF, 4'hF, 1'b1, 1'b0, 5, 16'h1234, 4'h0, 7, 16'h5678, 4'h0);
    run_frame("f3_5678", V5678, 4'hF, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Leading-zero suppression
    blank_lz = 1'b1;
    run_frame("f4_lzload", V5678, 4'hF, 1'b1, 1'b0, 0, 16'h0005, 4'h0, -1, 16'h0, 4'h0);
    run_frame("f5_lz5", LZ5, 4'hF, 1'b1, 1'b0, 0, 16'h0005, 4'b0100, -1, 16'h0, 4'h0);
    run_frame("f6_lzdp", LZ5DP, 4'b1011, 1'b1, 1'b0, 0, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
    run_frame("f7_lz0", LZ0, 4'hF, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Blink: frames with counter 0,1 scan, 2,3 dark
    blank_lz = 1'b0;
    blink_en = 1'b1;
    run_frame("f8_blk0", ZEROS, 4'hF, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("f9_blk1", ZEROS, 4'hF, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("f10_blk2", ZEROS, 4'hF, 1'b1, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("f11_blk3", ZEROS, 4'hF, 1'b1, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Blink disabled: counter keeps running but no frame goes dark
    blink_en = 1'b0;
    run_frame("f12_nb0", ZEROS, 4'hF, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("f13_nb1", ZEROS, 4'hF, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("f14_nb2", ZEROS, 4'hF, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Reset mid-scan at digit 2 with a pending value that must be discarded
    value = 16'h9999;
    dp_in = 4'hF;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    check_reset_outputs("mid_release");
    @(negedge clk);
    run_frame("r0_zero", ZEROS, 4'hF, 1'b0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("r1_zero", ZEROS, 4'hF, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
